// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-generic ALU with registered outputs, tag echo and iterative MUL/DIVU/REMU.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_dz,
  output logic             out_ill,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int LG = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [1:0] kind, ikind;
  logic [WIDTH-1:0] hi, lo, opnd, hi_n, lo_n, fin;
  logic [LG-1:0] cnt, sh;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] a, b, bb, sum, dif, pop, res;
  logic [WIDTH:0] s, t;
  logic acc, rt, ovf, ill, iter, add_ovf, sub_ovf, ge;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign busy = state == BUSY;
  assign acc = in_valid && in_ready;
  assign a = in_rs1;
  assign b = in_rs2;
  assign rt = in_opcode == 6'b000000;
  assign sh = b[LG-1:0];
  // INC/DEC reuse the adder/subtractor with an implicit operand of one
  assign bb = rt && (in_funct == 6'b001010 || in_funct == 6'b001011) ? WIDTH'(1) : b;
  assign sum = a + bb;
  assign dif = a - bb;
  assign add_ovf = a[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
  assign sub_ovf = a[WIDTH-1] != bb[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + WIDTH'(a[i]);
  end
  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    iter = 1'b0;
    ikind = 2'd0;
    if (rt) begin
      case (in_funct)
        6'b001000, 6'b001010: begin res = sum; ovf = add_ovf; end
        6'b001001, 6'b001011: begin res = dif; ovf = sub_ovf; end
        6'b010000: res = a & b;
        6'b010001: res = a | b;
        6'b010010: res = a ^ b;
        6'b010011: res = ~(a | b);
        6'b010100: res = ~a;
        6'b011001: res = a >> sh;
        6'b011010: res = $signed(a) >>> sh;
        6'b011011: res = a << sh;
        6'b001100: res = WIDTH'(a < b);
        6'b001101: res = WIDTH'(a > b);
        6'b101000: res = pop;
        6'b100000: iter = 1'b1;
        6'b100001: begin iter = 1'b1; ikind = 2'd1; end
        6'b100010: begin iter = 1'b1; ikind = 2'd2; end
        default: ill = 1'b1;
      endcase
    end else begin
      case (in_opcode)
        6'b001000: begin res = sum; ovf = add_ovf; end
        6'b001001: begin res = dif; ovf = sub_ovf; end
        6'b010000: res = a & b;
        6'b010001: res = a | b;
        6'b010010: res = a ^ b;
        6'b011000: res = a << sh;
        6'b011001: res = a >> sh;
        6'b011010: res = $signed(a) >>> sh;
        6'b110000: res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        default: ill = 1'b1;
      endcase
    end
  end
  // {hi,lo} is the shift-add product for MUL, or remainder/quotient for restoring division
  assign s = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign t = {hi, lo[WIDTH-1]};
  assign ge = t >= {1'b0, opnd};
  assign hi_n = kind == 2'd0 ? s[WIDTH:1] : ge ? t[WIDTH-1:0] - opnd : t[WIDTH-1:0];
  assign lo_n = kind == 2'd0 ? {s[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
  assign fin = kind == 2'd2 ? hi_n : lo_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_ovf <= 1'b0;
      out_dz <= 1'b0;
      out_ill <= 1'b0;
      out_tag <= '0;
      kind <= 2'd0;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
      cnt <= '0;
      tag_q <= '0;
    end else if (state == BUSY) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt - LG'(1);
      if (cnt == '0) begin
        state <= DONE;
        out_valid <= 1'b1;
        out_result <= fin;
        out_zero <= fin == '0;
        out_ovf <= kind == 2'd0 && hi_n != '0;
        out_dz <= kind != 2'd0 && opnd == '0;
        out_ill <= 1'b0;
        out_tag <= tag_q;
      end
    end else if (acc) begin
      if (iter) begin
        state <= BUSY;
        out_valid <= 1'b0;
        kind <= ikind;
        cnt <= LG'(WIDTH - 1);
        hi <= '0;
        lo <= ikind == 2'd0 ? b : a;
        opnd <= ikind == 2'd0 ? a : b;
        tag_q <= in_tag;
      end else begin
        state <= DONE;
        out_valid <= 1'b1;
        out_result <= res;
        out_zero <= res == '0;
        out_ovf <= ovf;
        out_dz <= 1'b0;
        out_ill <= ill;
        out_tag <= in_tag;
      end
    end else if (out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq at WIDTH=32 and WIDTH=16.
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [5:0] in_opcode = '0, in_funct = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0] in_tag = '0;
  logic in_ready, out_valid, out_zero, out_ovf, out_dz, out_ill, busy;
  logic [31:0] out_result;
  logic [4:0] out_tag;
  alu_seq #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_dz(out_dz), .out_ill(out_ill), .out_tag(out_tag), .busy(busy)
  );
  logic v16 = 1'b0, rdy16, o16v, z16, ov16, dz16, il16, busy16;
  logic [5:0] op16 = '0, fn16 = '0;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic [4:0] t16 = '0, t16o;
  alu_seq #(.WIDTH(16), .TAG_W(5)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .in_opcode(op16), .in_funct(fn16), .in_rs1(a16), .in_rs2(b16),
    .in_tag(t16), .out_valid(o16v), .out_ready(1'b1),
    .out_result(r16), .out_zero(z16), .out_ovf(ov16),
    .out_dz(dz16), .out_ill(il16), .out_tag(t16o), .busy(busy16)
  );
  localparam logic [5:0] R = 6'b000000;
  int checks = 0, failures = 0;
  typedef struct {string n; logic [31:0] r; logic o, d, i; logic [4:0] t;} exp_t;
  exp_t q[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_result", {out_result, out_tag}, 0);
      else begin
        e = q.pop_front();
        chk({"result_", e.n}, {out_result, out_zero, out_ovf, out_dz, out_ill, out_tag},
            {e.r, e.r == 32'h0, e.o, e.d, e.i, e.t});
      end
    end
  end
  task automatic send(input string n, input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                      input logic [31:0] r, input logic o = 1'b0, input logic d = 1'b0,
                      input logic i = 1'b0);
    exp_t e;
    int k = 0;
    in_valid = 1'b1; in_opcode = op; in_funct = fn; in_rs1 = a; in_rs2 = b; in_tag = tg;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    if (!in_ready) chk({n, "_accept"}, 0, 1);
    else begin
      e.n = n; e.r = r; e.o = o; e.d = d; e.i = i; e.t = tg;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_rs1 = $urandom; in_rs2 = $urandom; in_tag = 5'h1f;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic s16(input string n, input logic [5:0] op, input logic [5:0] fn,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                     input logic o, input int lat);
    int m = 0;
    v16 = 1'b1; op16 = op; fn16 = fn; a16 = a; b16 = b;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h5a5a; b16 = 16'h3c3c;
    do begin @(negedge clk); m++; end while (!o16v && m < 60);
    chk({n, "_w16"}, {o16v, r16, z16, ov16}, {1'b1, r, r == 16'h0, o});
    chk({n, "_w16_latency"}, m, lat);
    @(posedge clk); #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {out_valid, out_result, out_zero, out_ovf, out_dz, out_ill, out_tag, busy}, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send("add_ovf", R, 6'b001000, 32'h7fffffff, 32'h1, 5'd3, 32'h80000000, 1'b1);
    wait_valid(n);
    chk("add_latency", n, 1);
    @(posedge clk); #1;
    send("mul_ovf", R, 6'b100000, 32'h00010000, 32'h00010000, 5'd4, 32'h0, 1'b1);
    chk("busy_after_mul_accept", {busy, in_ready}, 2'b10);
    wait_valid(n);
    chk("mul_latency", n, 33);
    @(posedge clk); #1;
    send("mul", R, 6'b100000, 32'h1234, 32'h10, 5'd5, 32'h12340);
    send("mul_ff", R, 6'b100000, 32'hffffffff, 32'hffffffff, 5'd6, 32'h1, 1'b1);
    send("divu", R, 6'b100001, 32'd100, 32'd7, 5'd7, 32'd14);
    send("remu", R, 6'b100010, 32'd100, 32'd7, 5'd8, 32'd2);
    send("divu_big", R, 6'b100001, 32'hffffffff, 32'd3, 5'd9, 32'h55555555);
    send("remu_big", R, 6'b100010, 32'hffffffff, 32'd10, 5'd10, 32'd5);
    send("divu_dz", R, 6'b100001, 32'd5, 32'd0, 5'd11, 32'hffffffff, 1'b0, 1'b1);
    send("remu_dz", R, 6'b100010, 32'd5, 32'd0, 5'd12, 32'd5, 1'b0, 1'b1);
    send("sub_ovf", R, 6'b001001, 32'h80000000, 32'h1, 5'd13, 32'h7fffffff, 1'b1);
    send("dec_ovf", R, 6'b001011, 32'h80000000, 32'h12345, 5'd14, 32'h7fffffff, 1'b1);
    send("inc_wrap", R, 6'b001010, 32'hffffffff, 32'h12345, 5'd15, 32'h0);
    send("and", R, 6'b010000, 32'hf0f0f0f0, 32'hff00ff00, 5'd16, 32'hf000f000);
    send("or", R, 6'b010001, 32'hf0f0f0f0, 32'hff00ff00, 5'd17, 32'hfff0fff0);
    send("xor", R, 6'b010010, 32'hf0f0f0f0, 32'hff00ff00, 5'd18, 32'h0ff00ff0);
    send("nor", R, 6'b010011, 32'hf0f0f0f0, 32'hff00ff00, 5'd19, 32'h000f000f);
    send("not", R, 6'b010100, 32'hf0f0f0f0, 32'h0, 5'd20, 32'h0f0f0f0f);
    send("srl_mask", R, 6'b011001, 32'h80000000, 32'h3f, 5'd21, 32'h1);
    send("sla_mask", R, 6'b011011, 32'h3, 32'h24, 5'd22, 32'h30);
    send("slt", R, 6'b001100, 32'h1, 32'hffffffff, 5'd23, 32'h1);
    send("sgt", R, 6'b001101, 32'h1, 32'hffffffff, 5'd24, 32'h0);
    send("addi", 6'b001000, 6'b0, 32'h7ffffffe, 32'h1, 5'd25, 32'h7fffffff);
    send("subi", 6'b001001, 6'b0, 32'h0, 32'h1, 5'd26, 32'hffffffff);
    send("andi", 6'b010000, 6'b0, 32'h12345678, 32'hffff, 5'd27, 32'h5678);
    send("ori", 6'b010001, 6'b0, 32'h12340000, 32'h5678, 5'd28, 32'h12345678);
    send("xori", 6'b010010, 6'b0, 32'hffffffff, 32'hf, 5'd29, 32'hfffffff0);
    send("slai", 6'b011000, 6'b0, 32'h1, 32'd31, 5'd30, 32'h80000000);
    send("srli", 6'b011001, 6'b0, 32'h80000000, 32'd1, 5'd31, 32'h40000000);
    send("srai", 6'b011010, 6'b0, 32'h80000000, 32'd1, 5'd1, 32'hc0000000);
    send("ill_funct", R, 6'b111111, 32'h5, 32'h5, 5'd2, 32'h0, 1'b0, 1'b0, 1'b1);
    send("ill_opcode", 6'b111111, 6'b001000, 32'h5, 32'h5, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1);
    send("lui", 6'b110000, 6'b0, 32'h0, 32'hffffabcd, 5'd4, 32'habcd0000);
    drain();
    out_ready = 1'b0;
    send("sra_hold", R, 6'b011010, 32'hf0000000, 32'd4, 5'd7, 32'hff000000);
    wait_valid(n);
    chk("sra_latency", n, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, in_ready, out_result, out_tag}, {1'b1, 1'b0, 32'hff000000, 5'd7});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send("ham", R, 6'b101000, 32'h7, 32'h0, 5'd8, 32'h3);
    @(negedge clk);
    chk("ham_next_cycle", {out_valid, out_result}, {1'b1, 32'h3});
    @(posedge clk); #1;
    send("mul_rst", R, 6'b100000, 32'h3, 32'h5, 5'd9, 32'hf);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", {out_valid, out_result, out_zero, out_ovf, out_dz, out_ill, out_tag, busy}, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("post_reset_idle", {out_valid, in_ready, busy}, 3'b010);
    end
    @(posedge clk); #1;
    send("add_after_rst", R, 6'b001000, 32'h2, 32'h3, 5'd10, 32'h5);
    drain();
    s16("lui", 6'b110000, 6'b0, 16'h0, 16'h00ab, 16'hab00, 1'b0, 1);
    s16("sra", R, 6'b011010, 16'h8000, 16'd15, 16'hffff, 1'b0, 1);
    s16("mul", R, 6'b100000, 16'hffff, 16'hffff, 16'h0001, 1'b1, 17);
    s16("add_ovf", R, 6'b001000, 16'h7fff, 16'h1, 16'h8000, 1'b1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
